// File: rtl/circle_hit_counter.sv
// circle_hit_counter
//   Batch-controlled, multi-lane quarter-circle hit counter for the Monte
//   Carlo pi estimator. Each accepted beat carries LANES unsigned (x, y)
//   points; a point hits when x^2 + y^2 <= (2^WIDTH-1)^2. Hits and samples
//   are accumulated (saturating) over a batch of num_beats beats.
//
// Ports:
//   clk          rising-edge clock
//   resetn       asynchronous active-low reset
//   start        begin a batch (honoured in IDLE only)
//   abort        end a batch early (honoured in RUN and DRAIN)
//   num_beats    batch length in beats, sampled on an accepted start
//   in_valid     x/y beat valid
//   in_ready     beat accepted when in_valid & in_ready (high in RUN)
//   x, y         lane i at bits [i*WIDTH +: WIDTH]
//   busy         high in RUN or DRAIN
//   done         one-cycle pulse on normal batch completion
//   hit_count    saturating count of points inside the circle
//   sample_count saturating count of evaluated points
//   saturated    sticky flag, set when either count clips
module circle_hit_counter #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned LANES       = 4,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic                     abort,
  input  logic [COUNT_WIDTH-1:0]   num_beats,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*WIDTH-1:0]   x,
  input  logic [LANES*WIDTH-1:0]   y,
  output logic                     busy,
  output logic                     done,
  output logic [COUNT_WIDTH-1:0]   hit_count,
  output logic [COUNT_WIDTH-1:0]   sample_count,
  output logic                     saturated
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int unsigned PC_W  = $clog2(LANES + 1);
  // Headroom so that count + LANES (LANES <= 16) never wraps before clamping.
  localparam int unsigned SUM_W = COUNT_WIDTH + 5;

  localparam logic [2*WIDTH-1:0] RMAX_EXT = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
  localparam logic [2*WIDTH-1:0] LIMIT    = RMAX_EXT * RMAX_EXT;

  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic [COUNT_WIDTH-1:0] num_beats_q;
  logic [COUNT_WIDTH-1:0] beats_accepted;

  logic                   s1_valid;
  logic                   s2_valid;
  logic [2*WIDTH-1:0]     sq_x [LANES];
  logic [2*WIDTH-1:0]     sq_y [LANES];
  logic [LANES-1:0]       hit_vec;
  logic [LANES-1:0]       hit_nxt;
  logic [PC_W-1:0]        hit_pop;

  logic                   kill;
  logic                   accept;
  logic                   start_ok;
  logic                   last_beat;

  logic [SUM_W-1:0]       hit_sum;
  logic [SUM_W-1:0]       smp_sum;
  logic                   hit_clip;
  logic                   smp_clip;

  assign in_ready  = (state == S_RUN);
  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);

  // abort wins over a same-cycle accept; that beat never enters the pipe.
  assign kill      = abort & busy;
  assign accept    = in_valid & in_ready & ~abort;
  assign start_ok  = start & (state == S_IDLE);
  assign last_beat = accept & (beats_accepted == (num_beats_q - 1'b1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (num_beats != '0) ? S_RUN : S_DONE;
      S_RUN: begin
        if (abort)          state_nxt = S_IDLE;
        else if (last_beat) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)                      state_nxt = S_IDLE;
        else if (!s1_valid && !s2_valid) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    hit_nxt = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      hit_nxt[i] = ({1'b0, sq_x[i]} + {1'b0, sq_y[i]}) <= {1'b0, LIMIT};
    end
  end

  always_comb begin
    hit_pop = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      hit_pop = hit_pop + PC_W'(hit_vec[i]);
    end
  end

  assign hit_sum  = SUM_W'(hit_count) + SUM_W'(hit_pop);
  assign smp_sum  = SUM_W'(sample_count) + SUM_W'(LANES);
  assign hit_clip = |hit_sum[SUM_W-1:COUNT_WIDTH];
  assign smp_clip = |smp_sum[SUM_W-1:COUNT_WIDTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= S_IDLE;
      num_beats_q    <= '0;
      beats_accepted <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        num_beats_q    <= num_beats;
        beats_accepted <= '0;
      end else if (accept) begin
        beats_accepted <= beats_accepted + 1'b1;
      end
    end
  end

  // Stage 1: squares of each lane.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) begin
        sq_x[i] <= '0;
        sq_y[i] <= '0;
      end
    end else begin
      s1_valid <= accept;
      if (accept) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          sq_x[i] <= {{WIDTH{1'b0}}, x[i*WIDTH +: WIDTH]} * {{WIDTH{1'b0}}, x[i*WIDTH +: WIDTH]};
          sq_y[i] <= {{WIDTH{1'b0}}, y[i*WIDTH +: WIDTH]} * {{WIDTH{1'b0}}, y[i*WIDTH +: WIDTH]};
        end
      end
    end
  end

  // Stage 2: per-lane hit vector.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s2_valid <= 1'b0;
      hit_vec  <= '0;
    end else begin
      s2_valid <= s1_valid & ~kill;
      if (s1_valid) hit_vec <= hit_nxt;
    end
  end

  // Stage 3: saturating accumulation. A beat still in flight when abort is
  // taken is discarded, so the counters skip the update on that edge too.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hit_count    <= '0;
      sample_count <= '0;
      saturated    <= 1'b0;
    end else if (start_ok) begin
      hit_count    <= '0;
      sample_count <= '0;
      if (num_beats != '0) saturated <= 1'b0;
    end else if (s2_valid && !kill) begin
      hit_count    <= hit_clip ? '1 : hit_sum[COUNT_WIDTH-1:0];
      sample_count <= smp_clip ? '1 : smp_sum[COUNT_WIDTH-1:0];
      if (hit_clip || smp_clip) saturated <= 1'b1;
    end
  end

endmodule

// File: tb/tb_circle_hit_counter.sv
module tb_circle_hit_counter;

  localparam int unsigned W  = 16;
  localparam int unsigned L  = 4;
  localparam int unsigned CW = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic            start, abort, in_valid;
  logic [CW-1:0]   num_beats;
  logic [L*W-1:0]  x, y;
  logic            in_ready, busy, done, saturated;
  logic [CW-1:0]   hit_count, sample_count;

  logic            s_start, s_abort, s_valid;
  logic [3:0]      s_num;
  logic [L*W-1:0]  s_x, s_y;
  logic            s_in_ready, s_busy, s_done, s_sat;
  logic [3:0]      s_hit, s_smp;

  circle_hit_counter #(.WIDTH(W), .LANES(L), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .num_beats(num_beats), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .busy(busy), .done(done), .hit_count(hit_count),
    .sample_count(sample_count), .saturated(saturated)
  );

  circle_hit_counter #(.WIDTH(W), .LANES(L), .COUNT_WIDTH(4)) dut_small (
    .clk(clk), .resetn(resetn), .start(s_start), .abort(s_abort),
    .num_beats(s_num), .in_valid(s_valid), .in_ready(s_in_ready),
    .x(s_x), .y(s_y), .busy(s_busy), .done(s_done), .hit_count(s_hit),
    .sample_count(s_smp), .saturated(s_sat)
  );

  int checks = 0;
  int failures = 0;
  longint unsigned exp_hit, exp_smp;

  // Reference: count points with x^2 + y^2 <= 65535^2.
  function automatic int unsigned beat_hits(input logic [L*W-1:0] bx, input logic [L*W-1:0] by);
    longint unsigned r2 = 64'd65535 * 64'd65535;
    longint unsigned a, b;
    int unsigned n = 0;
    for (int i = 0; i < int'(L); i++) begin
      a = longint'(bx[i*W +: W]);
      b = longint'(by[i*W +: W]);
      if (a * a + b * b <= r2) n++;
    end
    return n;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    start = 0; abort = 0; in_valid = 0; num_beats = '0; x = '0; y = '0;
    s_start = 0; s_abort = 0; s_valid = 0; s_num = '0; s_x = '0; s_y = '0;
    resetn = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, busy, done, saturated} !== 4'b0 || hit_count !== '0 || sample_count !== '0) begin
      failures++;
      $display("FAIL reset_main: rdy=%b busy=%b done=%b sat=%b hit=%0d smp=%0d, expected all 0",
               in_ready, busy, done, saturated, hit_count, sample_count);
    end
    checks++;
    if ({s_in_ready, s_busy, s_done, s_sat} !== 4'b0 || s_hit !== '0 || s_smp !== '0) begin
      failures++;
      $display("FAIL reset_small: rdy=%b busy=%b done=%b sat=%b hit=%0d smp=%0d, expected all 0",
               s_in_ready, s_busy, s_done, s_sat, s_hit, s_smp);
    end
    #2 resetn = 1;
    tick;
    checks++;
    if (busy !== 0 || in_ready !== 0 || done !== 0) begin
      failures++;
      $display("FAIL reset_release: busy=%b rdy=%b done=%b, expected 0 0 0", busy, in_ready, done);
    end
  endtask

  // mode 0: fixed boundary beat, 1: random with in_valid held high,
  // 2: random with throttled in_valid and stray start pulses.
  task automatic run_batch(input int unsigned n, input int mode, input string name,
                           input logic [L*W-1:0] fx, input logic [L*W-1:0] fy);
    int unsigned acc = 0;
    int unsigned cyc = 0;
    logic exp_busy, exp_done;
    exp_hit = 0; exp_smp = 0;
    num_beats = n; start = 1;
    tick;
    start = 0;
    checks++;
    if (busy !== 1 || in_ready !== 1 || done !== 0 || hit_count !== '0 || sample_count !== '0) begin
      failures++;
      $display("FAIL %s_start: busy=%b rdy=%b done=%b hit=%0d smp=%0d, expected 1 1 0 0 0",
               name, busy, in_ready, done, hit_count, sample_count);
    end
    while (acc < n && cyc < n * 20 + 100) begin
      if (mode == 0) begin
        x = fx; y = fy; in_valid = 1;
      end else begin
        x = {$urandom, $urandom};
        y = {$urandom, $urandom};
        in_valid = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      if (mode == 2) begin
        start = ($urandom_range(0, 7) == 0);
        num_beats = $urandom;
      end
      checks++;
      if (in_ready !== 1) begin
        failures++;
        $display("FAIL %s_ready: cycle %0d in_ready=%b, expected 1", name, cyc, in_ready);
      end
      if (in_valid) begin
        acc++;
        exp_hit += beat_hits(x, y);
        exp_smp += L;
      end
      cyc++;
      tick;
    end
    start = 0;
    checks++;
    if (acc < n) begin
      failures++;
      $display("FAIL %s_timeout: accepted %0d beats, required %0d", name, acc, n);
    end
    for (int k = 0; k <= 4; k++) begin
      exp_busy = (k < 3);
      exp_done = (k == 3);
      checks++;
      if (in_ready !== 0 || busy !== exp_busy || done !== exp_done) begin
        failures++;
        $display("FAIL %s_tail: E+%0d rdy=%b busy=%b done=%b, expected 0 %b %b",
                 name, k, in_ready, busy, done, exp_busy, exp_done);
      end
      if (k >= 2) begin
        checks++;
        if (hit_count !== CW'(exp_hit) || sample_count !== CW'(exp_smp)) begin
          failures++;
          $display("FAIL %s_counts: E+%0d hit=%0d smp=%0d, expected %0d %0d",
                   name, k, hit_count, sample_count, exp_hit, exp_smp);
        end
      end
      tick;
    end
    in_valid = 0;
  endtask

  task automatic test_boundary;
    run_batch(1, 0, "boundary",
              {16'hB504, 16'h0000, 16'hFFFF, 16'hFFFF},
              {16'hB504, 16'h0000, 16'hFFFF, 16'h0000});
    checks++;
    if (hit_count !== 32'd3 || sample_count !== 32'd4 || saturated !== 0) begin
      failures++;
      $display("FAIL boundary_fixed: hit=%0d smp=%0d sat=%b, expected 3 4 0",
               hit_count, sample_count, saturated);
    end
  endtask

  task automatic test_back_to_back;
    run_batch(1000, 1, "back_to_back", '0, '0);
    checks++;
    if (sample_count !== 32'd4000 || busy !== 0) begin
      failures++;
      $display("FAIL back_to_back_final: smp=%0d busy=%b, expected 4000 0", sample_count, busy);
    end
  endtask

  task automatic test_throttled;
    run_batch(150, 2, "throttled", '0, '0);
  endtask

  task automatic test_zero_length;
    num_beats = '0; start = 1;
    tick;
    start = 0;
    checks++;
    if (done !== 1 || in_ready !== 0 || busy !== 0 || hit_count !== '0 || sample_count !== '0) begin
      failures++;
      $display("FAIL zero_len_done: done=%b rdy=%b busy=%b hit=%0d smp=%0d, expected 1 0 0 0 0",
               done, in_ready, busy, hit_count, sample_count);
    end
    tick;
    checks++;
    if (done !== 0 || in_ready !== 0) begin
      failures++;
      $display("FAIL zero_len_after: done=%b rdy=%b, expected 0 0", done, in_ready);
    end
  endtask

  task automatic test_abort_accept;
    exp_hit = 0; exp_smp = 0;
    num_beats = 10; start = 1;
    tick;
    start = 0;
    for (int i = 0; i < 3; i++) begin
      x = {$urandom, $urandom}; y = {$urandom, $urandom}; in_valid = 1;
      exp_hit += beat_hits(x, y); exp_smp += L;
      tick;
    end
    in_valid = 0;
    repeat (3) tick;
    checks++;
    if (hit_count !== CW'(exp_hit) || sample_count !== CW'(exp_smp) || in_ready !== 1) begin
      failures++;
      $display("FAIL abort_acc_partial: hit=%0d smp=%0d rdy=%b, expected %0d %0d 1",
               hit_count, sample_count, in_ready, exp_hit, exp_smp);
    end
    x = '0; y = '0; in_valid = 1; abort = 1;
    tick;
    abort = 0; in_valid = 0;
    checks++;
    if (busy !== 0 || in_ready !== 0 || done !== 0) begin
      failures++;
      $display("FAIL abort_acc_idle: busy=%b rdy=%b done=%b, expected 0 0 0", busy, in_ready, done);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (done !== 0 || hit_count !== CW'(exp_hit) || sample_count !== CW'(exp_smp)) begin
        failures++;
        $display("FAIL abort_acc_hold: +%0d done=%b hit=%0d smp=%0d, expected 0 %0d %0d",
                 k, done, hit_count, sample_count, exp_hit, exp_smp);
      end
      tick;
    end
  endtask

  task automatic test_abort_drain;
    exp_hit = 0; exp_smp = 0;
    num_beats = 4; start = 1;
    tick;
    start = 0;
    for (int i = 0; i < 3; i++) begin
      x = {$urandom, $urandom}; y = {$urandom, $urandom}; in_valid = 1;
      exp_hit += beat_hits(x, y); exp_smp += L;
      tick;
    end
    in_valid = 0;
    repeat (3) tick;
    x = '0; y = '0; in_valid = 1;
    tick;
    in_valid = 0;
    checks++;
    if (in_ready !== 0 || busy !== 1) begin
      failures++;
      $display("FAIL abort_drain_state: rdy=%b busy=%b, expected 0 1", in_ready, busy);
    end
    abort = 1;
    tick;
    abort = 0;
    checks++;
    if (busy !== 0 || done !== 0) begin
      failures++;
      $display("FAIL abort_drain_idle: busy=%b done=%b, expected 0 0", busy, done);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (done !== 0 || hit_count !== CW'(exp_hit) || sample_count !== CW'(exp_smp)) begin
        failures++;
        $display("FAIL abort_drain_hold: +%0d done=%b hit=%0d smp=%0d, expected 0 %0d %0d",
                 k, done, hit_count, sample_count, exp_hit, exp_smp);
      end
      tick;
    end
    num_beats = 2; start = 1;
    tick;
    start = 0;
    checks++;
    if (hit_count !== '0 || sample_count !== '0 || busy !== 1) begin
      failures++;
      $display("FAIL abort_restart_clear: hit=%0d smp=%0d busy=%b, expected 0 0 1",
               hit_count, sample_count, busy);
    end
    abort = 1;
    tick;
    abort = 0;
    checks++;
    if (busy !== 0) begin
      failures++;
      $display("FAIL abort_restart_idle: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_saturation;
    s_num = 4'd5; s_start = 1;
    tick;
    s_start = 0;
    checks++;
    if (s_sat !== 0 || s_busy !== 1) begin
      failures++;
      $display("FAIL sat_start: sat=%b busy=%b, expected 0 1", s_sat, s_busy);
    end
    s_x = '0; s_y = '0; s_valid = 1;
    repeat (5) tick;
    s_valid = 0;
    repeat (3) tick;
    checks++;
    if (s_done !== 1 || s_hit !== 4'd15 || s_smp !== 4'd15 || s_sat !== 1) begin
      failures++;
      $display("FAIL sat_final: done=%b hit=%0d smp=%0d sat=%b, expected 1 15 15 1",
               s_done, s_hit, s_smp, s_sat);
    end
    tick;
  endtask

  task automatic test_reset_midrun;
    num_beats = 50; start = 1;
    tick;
    start = 0;
    in_valid = 1;
    repeat (6) begin
      x = {$urandom, $urandom}; y = {$urandom, $urandom};
      tick;
    end
    checks++;
    if (sample_count !== 32'd16) begin
      failures++;
      $display("FAIL rst_mid_pre: smp=%0d, expected 16", sample_count);
    end
    #3 resetn = 0;
    #1;
    checks++;
    if ({in_ready, busy, done, saturated} !== 4'b0 || hit_count !== '0 || sample_count !== '0) begin
      failures++;
      $display("FAIL rst_mid_async: rdy=%b busy=%b done=%b sat=%b hit=%0d smp=%0d, expected all 0",
               in_ready, busy, done, saturated, hit_count, sample_count);
    end
    in_valid = 0;
    #1 resetn = 1;
    tick;
    tick;
    checks++;
    if (busy !== 0 || in_ready !== 0 || sample_count !== '0) begin
      failures++;
      $display("FAIL rst_mid_after: busy=%b rdy=%b smp=%0d, expected 0 0 0", busy, in_ready, sample_count);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_boundary();
    test_back_to_back();
    test_throttled();
    test_zero_length();
    test_abort_accept();
    test_abort_drain();
    test_saturation();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
